// File: rtl/ovl_pkg.sv
// Shared overlay-stream definitions: beat field positions, FSM states and the
// queued memory-write record. Also used by the overlay generator.
package ovl_pkg;

   localparam int OVL_BEAT_W    = 54;
   localparam int OVL_MASK_HI   = 53;
   localparam int OVL_MASK_LO   = 50;
   localparam int OVL_FRAME_BIT = 49;
   localparam int OVL_ADDR_HI   = 48;
   localparam int OVL_ADDR_LO   = 32;
   localparam int OVL_PIX_HI    = 31;
   localparam int OVL_PIX_LO    = 0;

   typedef enum logic [2:0] {
      OVL_IDLE,
      OVL_START,
      OVL_STREAM,
      OVL_DRAIN,
      OVL_ACK
   } ovl_wr_state_e;

   typedef struct packed {
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } ovl_wr_t;

   localparam int OVL_WR_W = $bits(ovl_wr_t);

   // Byte address of a word inside the selected double buffer; wraps at 32 bits.
   function automatic logic [31:0] ovl_byte_addr(input logic        frame,
                                                 input logic [31:0] fb0_base,
                                                 input logic [31:0] fb1_base,
                                                 input logic [31:0] word_addr);
      return (frame ? fb1_base : fb0_base) + (word_addr << 2);
   endfunction

endpackage

// File: rtl/ovl_sync_fifo.sv
// Synchronous FIFO with a register-held head: a push shows at the output one cycle later.
// Backpressure via full; push with pop while full is allowed and keeps the count.
module ovl_sync_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/overlay_fb_writer.sv
// Requests an overlay frame, turns 54-bit beats into masked 32-bit frame-buffer writes, then flips disp_frame.
// Beat to mem_wvalid is one cycle minimum; din_ready drops when the write FIFO is full; mem_* hold until mem_wready.
module overlay_fb_writer
   import ovl_pkg::*;
#(
   parameter logic [31:0] FB0_BASE   = 32'h1000_0000,
   parameter logic [31:0] FB1_BASE   = 32'h1002_0000,
   parameter int          ADDR_W     = 17,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  frame_req,
   output logic                  start,
   input  logic                  start_ack,
   input  logic                  done,
   output logic                  done_ack,
   input  logic [OVL_BEAT_W-1:0] din,
   input  logic                  din_valid,
   output logic                  din_ready,
   output logic [31:0]           mem_waddr,
   output logic [31:0]           mem_wdata,
   output logic [3:0]            mem_wmask,
   output logic                  mem_wvalid,
   input  logic                  mem_wready,
   output logic                  disp_frame,
   output logic                  busy,
   output logic                  err_frame
);

   ovl_wr_state_e     state;
   ovl_wr_state_e     state_nxt;
   logic              beat_window;
   logic              accept;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [3:0]        beat_mask;
   logic              beat_frame;
   logic [ADDR_W-1:0] beat_addr;
   logic [31:0]       beat_pix;
   ovl_wr_t           wr_in;
   ovl_wr_t           wr_head;
   logic              frame_cur;
   logic              frame_seen;

   assign beat_mask  = din[OVL_MASK_HI:OVL_MASK_LO];
   assign beat_frame = din[OVL_FRAME_BIT];
   assign beat_addr  = din[OVL_ADDR_HI:OVL_ADDR_LO];
   assign beat_pix   = din[OVL_PIX_HI:OVL_PIX_LO];

   assign din_ready  = beat_window & ~fifo_full;
   assign accept     = din_valid & din_ready;
   // Empty-mask beats are consumed here and never reach the write queue.
   assign fifo_push  = accept & (beat_mask != 4'h0);
   assign mem_wvalid = ~fifo_empty;
   assign fifo_pop   = mem_wvalid & mem_wready;

   always_comb begin
      wr_in       = '0;
      wr_in.waddr = ovl_byte_addr(beat_frame, FB0_BASE, FB1_BASE, 32'(beat_addr));
      wr_in.wdata = beat_pix;
      wr_in.wmask = beat_mask;
   end

   ovl_sync_fifo #(
      .WIDTH (OVL_WR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (fifo_push),
      .push_dat (wr_in),
      .pop      (fifo_pop),
      .pop_dat  (wr_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign mem_waddr = wr_head.waddr;
   assign mem_wdata = wr_head.wdata;
   assign mem_wmask = wr_head.wmask;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= OVL_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      start       = 1'b0;
      done_ack    = 1'b0;
      beat_window = 1'b0;
      busy        = (state != OVL_IDLE);
      case (state)
         OVL_IDLE: begin
            if (frame_req) state_nxt = OVL_START;
         end
         OVL_START: begin
            // done seen here is a generator protocol error and is deliberately ignored.
            start = 1'b1;
            if (start_ack) state_nxt = OVL_STREAM;
         end
         OVL_STREAM: begin
            beat_window = 1'b1;
            if (done) state_nxt = OVL_DRAIN;
         end
         OVL_DRAIN: begin
            beat_window = 1'b1;
            if (fifo_empty && !din_valid) state_nxt = OVL_ACK;
         end
         OVL_ACK: begin
            done_ack = 1'b1;
            if (!done) state_nxt = OVL_IDLE;
         end
         default: state_nxt = OVL_IDLE;
      endcase
   end

   // The first beat of each frame fixes the frame bit; later disagreement is flagged but still written.
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_cur  <= 1'b0;
         frame_seen <= 1'b0;
         err_frame  <= 1'b0;
         disp_frame <= 1'b0;
      end else begin
         if (state == OVL_START) begin
            frame_seen <= 1'b0;
         end else if (accept) begin
            if (!frame_seen) begin
               frame_cur  <= beat_frame;
               frame_seen <= 1'b1;
            end else if (beat_frame != frame_cur) begin
               err_frame <= 1'b1;
            end
         end
         if (state == OVL_ACK && !done) begin
            disp_frame <= frame_cur;
         end
      end
   end

endmodule

// File: tb/tb_overlay_fb_writer.sv
// Bench for overlay_fb_writer: directed protocol steps plus random beats against a queue-based write model.
module tb_overlay_fb_writer;

   localparam logic [31:0] FB0   = 32'h1000_0000;
   localparam logic [31:0] FB1   = 32'h1002_0000;
   localparam int          DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        frame_req = 1'b0;
   logic        start;
   logic        start_ack = 1'b0;
   logic        done = 1'b0;
   logic        done_ack;
   logic [53:0] din = '0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_wvalid;
   logic        mem_wready = 1'b0;
   logic        disp_frame;
   logic        busy;
   logic        err_frame;

   overlay_fb_writer dut (
      .clock      (clock),
      .reset      (reset),
      .frame_req  (frame_req),
      .start      (start),
      .start_ack  (start_ack),
      .done       (done),
      .done_ack   (done_ack),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_wmask  (mem_wmask),
      .mem_wvalid (mem_wvalid),
      .mem_wready (mem_wready),
      .disp_frame (disp_frame),
      .busy       (busy),
      .err_frame  (err_frame)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  m;
   } wr_t;

   int   compared   = 0;
   int   mismatched = 0;
   wr_t  exp_q[$];
   logic m_seen = 1'b0;
   logic m_frame = 1'b0;
   logic m_err = 1'b0;
   logic hold_pend = 1'b0;
   wr_t  hold_val;
   logic last_acc = 1'b0;
   int   n_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [53:0] mk_beat(input logic [3:0] m, input logic f,
                                           input logic [16:0] a, input logic [31:0] p);
      return {m, f, a, p};
   endfunction

   function automatic logic [53:0] rnd_beat(input logic f, input logic allow_zero);
      logic [3:0] m;
      m = 4'($urandom_range(15, allow_zero ? 0 : 1));
      return {m, f, 17'($urandom), 32'($urandom)};
   endfunction

   // Reference: every accepted beat with a nonzero mask becomes one write, in order.
   task automatic model_accept(input logic [53:0] b);
      logic [3:0]  m;
      logic        f;
      logic [16:0] a;
      wr_t         e;
      m = b[53:50];
      f = b[49];
      a = b[48:32];
      if (!m_seen) begin
         m_seen  = 1'b1;
         m_frame = f;
      end else if (f != m_frame) begin
         m_err = 1'b1;
      end
      if (m != 4'h0) begin
         e.a = (f ? FB1 : FB0) + 32'(a) * 4;
         e.d = b[31:0];
         e.m = m;
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      wr_t e;
      @(negedge clock);
      last_acc = 1'b0;
      if (!reset) begin
         if (hold_pend) begin
            chk("hold_valid", mem_wvalid, 1);
            chk("hold_write", {mem_waddr, mem_wdata, mem_wmask}, hold_val);
         end
         if (mem_wvalid && mem_wready) begin
            chk("write_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("wr_addr", mem_waddr, e.a);
               chk("wr_data", mem_wdata, e.d);
               chk("wr_mask", mem_wmask, e.m);
            end
         end
         hold_pend = mem_wvalid && !mem_wready;
         hold_val  = {mem_waddr, mem_wdata, mem_wmask};
         last_acc  = din_valid && din_ready;
         if (last_acc) model_accept(din);
      end else begin
         hold_pend = 1'b0;
      end
      @(posedge clock);
      #1;
      if (!reset) chk("err_frame_model", err_frame, m_err);
   endtask

   initial begin
      // Reset state
      repeat (3) tick();
      chk("rst_start", start, 0);
      chk("rst_done_ack", done_ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_din_ready", din_ready, 0);
      chk("rst_mem_wvalid", mem_wvalid, 0);
      chk("rst_disp_frame", disp_frame, 0);
      chk("rst_err_frame", err_frame, 0);
      chk("rst_mem_waddr", mem_waddr, 0);
      reset = 1'b0;
      tick();
      chk("idle_busy", busy, 0);

      // Start handshake
      frame_req = 1'b1;
      m_seen = 1'b0;
      tick();
      frame_req = 1'b0;
      chk("start_rise", start, 1);
      chk("start_busy", busy, 1);
      chk("start_din_ready", din_ready, 0);
      tick();
      chk("start_hold", start, 1);
      start_ack = 1'b1;
      tick();
      start_ack = 1'b0;
      chk("start_fall", start, 0);
      chk("stream_busy", busy, 1);
      chk("stream_din_ready", din_ready, 1);

      // Single directed beat
      mem_wready = 1'b1;
      din = mk_beat(4'hF, 1'b1, 17'h00003, 32'hA5A5_A5A5);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("beat1_acc", last_acc, 1);
      chk("beat1_wvalid", mem_wvalid, 1);
      chk("beat1_waddr", mem_waddr, 32'h1002_000C);
      chk("beat1_wdata", mem_wdata, 32'hA5A5_A5A5);
      chk("beat1_wmask", mem_wmask, 4'hF);
      tick();
      chk("beat1_drained", mem_wvalid, 0);
      chk("beat1_q", exp_q.size(), 0);

      // Fill the FIFO with the memory stalled
      mem_wready = 1'b0;
      n_acc = 0;
      din = rnd_beat(1'b1, 1'b0);
      din_valid = 1'b1;
      for (int i = 0; i < 12 && din_ready; i++) begin
         tick();
         if (last_acc) begin
            n_acc++;
            din = rnd_beat(1'b1, 1'b0);
         end
      end
      din_valid = 1'b0;
      chk("fill_count", n_acc, DEPTH);
      chk("full_din_ready", din_ready, 0);
      chk("full_q", exp_q.size(), DEPTH);
      tick();
      chk("full_wvalid", mem_wvalid, 1);
      mem_wready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("fill_drain_q", exp_q.size(), 0);
      chk("fill_drain_wvalid", mem_wvalid, 0);

      // Random beats and memory stalls
      for (int i = 0; i < 300; i++) begin
         if (!din_valid || last_acc) begin
            if ($urandom_range(3) != 0) begin
               din = rnd_beat(1'b1, 1'b1);
               din_valid = 1'b1;
            end else begin
               din_valid = 1'b0;
            end
         end
         mem_wready = ($urandom_range(3) != 0);
         tick();
      end
      din_valid = 1'b0;
      mem_wready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      chk("rand_drain_q", exp_q.size(), 0);

      // Empty-mask beat writes nothing
      din = mk_beat(4'h0, 1'b1, 17'h00005, 32'hDEAD_BEEF);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("mask0_acc", last_acc, 1);
      chk("mask0_wvalid", mem_wvalid, 0);
      tick();
      chk("mask0_wvalid2", mem_wvalid, 0);

      // Frame bit changes mid-frame
      din = mk_beat(4'h3, 1'b0, 17'h00010, 32'h1234_5678);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("ferr_set", err_frame, 1);
      chk("ferr_waddr", mem_waddr, 32'h1000_0040);
      repeat (3) tick();
      chk("ferr_sticky", err_frame, 1);

      // Last beat carries done
      mem_wready = 1'b0;
      din = mk_beat(4'hC, 1'b1, 17'h1FFFF, 32'($urandom));
      din_valid = 1'b1;
      done = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("last_acc", last_acc, 1);
      chk("drain_done_ack", done_ack, 0);
      chk("drain_busy", busy, 1);
      chk("drain_wvalid", mem_wvalid, 1);
      tick();
      chk("drain_wait", done_ack, 0);
      mem_wready = 1'b1;
      for (int i = 0; i < 10 && !done_ack; i++) tick();
      chk("ack_rise", done_ack, 1);
      chk("ack_q", exp_q.size(), 0);
      tick();
      chk("ack_hold", done_ack, 1);
      done = 1'b0;
      tick();
      chk("ack_fall", done_ack, 0);
      chk("disp_flip", disp_frame, 1);
      chk("end_busy", busy, 0);

      // Second frame: done during START is ignored, then reset mid-stream
      frame_req = 1'b1;
      m_seen = 1'b0;
      tick();
      frame_req = 1'b0;
      done = 1'b1;
      tick();
      chk("start_done_ignored", start, 1);
      chk("start_no_ack", done_ack, 0);
      done = 1'b0;
      start_ack = 1'b1;
      tick();
      start_ack = 1'b0;
      chk("f2_din_ready", din_ready, 1);
      mem_wready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din = rnd_beat(1'b0, 1'b0);
         din_valid = 1'b1;
         tick();
         chk("f2_acc", last_acc, 1);
      end
      din_valid = 1'b0;
      chk("f2_wvalid", mem_wvalid, 1);
      reset = 1'b1;
      exp_q.delete();
      m_err = 1'b0;
      m_seen = 1'b0;
      tick();
      chk("mrst_wvalid", mem_wvalid, 0);
      chk("mrst_start", start, 0);
      chk("mrst_done_ack", done_ack, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_din_ready", din_ready, 0);
      chk("mrst_err_frame", err_frame, 0);
      chk("mrst_disp_frame", disp_frame, 0);
      reset = 1'b0;
      mem_wready = 1'b1;
      repeat (3) tick();
      chk("post_rst_wvalid", mem_wvalid, 0);
      chk("post_rst_busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
